// File: rtl/ws2812_pkg.sv
// ============================================================================
//  Module   : ws2812_pkg
//  Purpose  : Shared types and default timing constants for the WS2812 TX.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  typedef logic [23:0] pixel_t;

  localparam int DEF_T0H   = 5;
  localparam int DEF_T1H   = 10;
  localparam int DEF_TBIT  = 15;
  localparam int DEF_TRST  = 960;
  localparam int DEF_DEPTH = 4;
  localparam int PIX_BITS  = 24;

endpackage

`default_nettype wire

// File: rtl/ws2812_tx_fifo.sv
// ============================================================================
//  Module   : pixel_fifo
//  Purpose  : First-word-fall-through FIFO; DEPTH must be a power of two >= 2.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ws2812_tx.sv
// ============================================================================
//  Module   : ws2812_tx
//  Purpose  : Buffered WS2812 serialiser. Define WS2812_RGB_ORDER_EN for
//             R,G,B wire order (WS2811); default order is G,R,B.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ws2812_tx
  import ws2812_pkg::*;
#(
  parameter int T0H   = DEF_T0H,
  parameter int T1H   = DEF_T1H,
  parameter int TBIT  = DEF_TBIT,
  parameter int TRST  = DEF_TRST,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  input  logic       valid_i,
  output logic       dout,
  output logic       busy,
  output logic       overflow
);

  localparam int CMAX = (TRST > TBIT) ? TRST : TBIT;
  localparam int CW   = $clog2(CMAX + 1);

  state_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    bit_q, bit_d;
  pixel_t        shift_q, shift_d;
  logic          dout_q;
  logic          ovf_q;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  pixel_t        fifo_rdata;
  logic [CW-1:0] hi_len;
  logic [CW-1:0] lo_len;

  function automatic pixel_t to_wire(input pixel_t rgb);
`ifdef WS2812_RGB_ORDER_EN
    return rgb;
`else
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
`endif
  endfunction

  assign fifo_push = valid_i && (!fifo_full || fifo_pop);

  pixel_fifo #(
    .WIDTH (PIX_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (fifo_push),
    .wdata_i ({r, g, b}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The MSB of the shift register is the bit currently on the wire.
  assign hi_len = shift_q[23] ? CW'(T1H) : CW'(T0H);
  assign lo_len = CW'(TBIT) - hi_len;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = to_wire(fifo_rdata);
          bit_d    = '0;
          cnt_d    = '0;
          state_d  = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (cnt_q == hi_len - CW'(1)) begin
          cnt_d   = '0;
          state_d = ST_LOW;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_LOW: begin
        if (cnt_q == lo_len - CW'(1)) begin
          cnt_d = '0;
          if (bit_q == 5'd23) begin
            bit_d = '0;
            // Chain the next pixel seamlessly when one is already waiting.
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = to_wire(fifo_rdata);
              state_d  = ST_HIGH;
            end else begin
              state_d = ST_LATCH;
            end
          end else begin
            bit_d   = bit_q + 5'd1;
            shift_d = {shift_q[22:0], 1'b0};
            state_d = ST_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_LATCH: begin
        if (cnt_q == CW'(TRST - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      dout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      dout_q  <= (state_d == ST_HIGH);
      if (valid_i && fifo_full && !fifo_pop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign dout     = dout_q;
  assign busy     = !fifo_empty || (state_q != ST_IDLE);
  assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_ws2812_tx.sv
// ============================================================================
//  Module   : tb_ws2812_tx
//  Purpose  : Self-checking bench for ws2812_tx against a timeline model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ws2812_tx;

  localparam int T0H   = 5;
  localparam int T1H   = 10;
  localparam int TBIT  = 15;
  localparam int TRST  = 960;
  localparam int DEPTH = 4;
  localparam int PIX   = 24 * TBIT;
  localparam int MAXC  = 12000;

  logic       clock;
  logic       reset;
  logic [7:0] r, g, b;
  logic       valid_i;
  logic       dout;
  logic       busy;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  // Stimulus: arrival cycle and {r,g,b} of each pixel
  int          s_n;
  int          s_arr [16];
  logic [23:0] s_pix [16];

  // Model: accepted pixels, their wire word, first high cycle, frame end
  int          m_n;
  int          m_a  [16];
  logic [23:0] m_w  [16];
  int          m_st [16];
  int          m_fe [16];
  int          m_drop;

  bit tr_d [MAXC];
  bit tr_b [MAXC];
  bit tr_o [MAXC];
  int tr_len;

  ws2812_tx #(
    .T0H   (T0H),
    .T1H   (T1H),
    .TBIT  (TBIT),
    .TRST  (TRST),
    .DEPTH (DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .r        (r),
    .g        (g),
    .b        (b),
    .valid_i  (valid_i),
    .dout     (dout),
    .busy     (busy),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [23:0] wire_word(input logic [23:0] rgb);
`ifdef WS2812_RGB_ORDER_EN
    return rgb;
`else
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
`endif
  endfunction

  function automatic void compute_model();
    int a, occ, st, e;
    bit popnow;
    m_n = 0;
    m_drop = -1;
    for (int i = 0; i < s_n; i++) begin
      a = s_arr[i];
      occ = m_n;
      popnow = 0;
      for (int j = 0; j < m_n; j++) begin
        if (m_st[j] - 1 < a) occ--;
        if (m_st[j] - 1 == a) popnow = 1;
      end
      if (occ < DEPTH || popnow) begin
        m_a[m_n] = a;
        m_w[m_n] = wire_word(s_pix[i]);
        if (m_n == 0) st = a + 2;
        else begin
          e = m_st[m_n-1] + PIX;
          if (a + 2 <= e) st = e;
          else st = (a + 2 > e + TRST + 1) ? a + 2 : e + TRST + 1;
        end
        m_st[m_n] = st;
        m_n++;
      end else if (m_drop < 0) begin
        m_drop = a;
      end
    end
    for (int k = m_n - 1; k >= 0; k--) begin
      e = m_st[k] + PIX;
      if (k + 1 < m_n && m_st[k+1] == e) m_fe[k] = m_fe[k+1];
      else m_fe[k] = e;
    end
  endfunction

  function automatic bit exp_dout(input int c);
    int idx, ph;
    bit v;
    for (int k = 0; k < m_n; k++) begin
      if (c >= m_st[k] && c < m_st[k] + PIX) begin
        idx = (c - m_st[k]) / TBIT;
        ph  = (c - m_st[k]) % TBIT;
        v   = m_w[k][23 - idx];
        return ph < (v ? T1H : T0H);
      end
    end
    return 1'b0;
  endfunction

  function automatic bit exp_busy(input int c);
    for (int k = 0; k < m_n; k++)
      if (c >= m_a[k] + 1 && c < m_fe[k] + TRST) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    valid_i = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic run_scenario(input string name);
    int L, nd, nb, no, fd, fb, fo;
    compute_model();
    L = s_arr[s_n-1] + 10;
    for (int k = 0; k < m_n; k++)
      if (m_fe[k] + TRST + 10 > L) L = m_fe[k] + TRST + 10;
    if (L > MAXC) L = MAXC;
    do_reset();
    for (int c = 0; c < L; c++) begin
      valid_i = 1'b0;
      for (int i = 0; i < s_n; i++)
        if (s_arr[i] == c) begin
          valid_i = 1'b1;
          {r, g, b} = s_pix[i];
        end
      @(negedge clock);
      tr_d[c] = dout;
      tr_b[c] = busy;
      tr_o[c] = overflow;
      @(posedge clock);
      #1;
    end
    valid_i = 1'b0;
    tr_len = L;
    nd = 0; nb = 0; no = 0; fd = -1; fb = -1; fo = -1;
    for (int c = 0; c < L; c++) begin
      if (tr_d[c] !== exp_dout(c)) begin nd++; if (fd < 0) fd = c; end
      if (tr_b[c] !== exp_busy(c)) begin nb++; if (fb < 0) fb = c; end
      if (tr_o[c] !== (m_drop >= 0 && c > m_drop)) begin no++; if (fo < 0) fo = c; end
    end
    checks += 3;
    if (nd != 0) begin
      errors++;
      $display("FAIL %s dout: %0d cycles differ, first cycle %0d got %b expected %b",
               name, nd, fd, tr_d[fd], exp_dout(fd));
    end
    if (nb != 0) begin
      errors++;
      $display("FAIL %s busy: %0d cycles differ, first cycle %0d got %b expected %b",
               name, nb, fb, tr_b[fb], exp_busy(fb));
    end
    if (no != 0) begin
      errors++;
      $display("FAIL %s overflow: %0d cycles differ, first cycle %0d got %b",
               name, no, fo, tr_o[fo]);
    end
  endtask

  function automatic int count_pulses();
    int n = 0;
    for (int c = 1; c < tr_len; c++)
      if (tr_d[c] && !tr_d[c-1]) n++;
    return n;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    valid_i = 1'b1;
    {r, g, b} = 24'hA5A5A5;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    valid_i = 1'b0;
    @(negedge clock);
    checks += 3;
    if (dout !== 1'b0) begin errors++; $display("FAIL reset dout got %b expected 0", dout); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b expected 0", busy); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow got %b expected 0", overflow); end
    @(posedge clock);
    #1;
  endtask

  task automatic test_single_pixel();
    int hi, np, bad, run, idx;
    logic [23:0] w;
    s_n = 1; s_arr[0] = 0; s_pix[0] = 24'hFF0080;
    run_scenario("single_pixel");
    w = wire_word(s_pix[0]);
    hi = 0; np = 0; bad = 0; run = 0; idx = 0;
    for (int c = 0; c < tr_len; c++) begin
      if (tr_d[c]) begin hi++; run++; end
      else if (run != 0) begin
        if (idx < 24 && run != (w[23-idx] ? T1H : T0H)) bad++;
        idx++; np++; run = 0;
      end
    end
    checks += 2;
    if (hi != 165) begin errors++; $display("FAIL single_hi_cycles got %0d expected 165", hi); end
    if (np != 24 || bad != 0) begin
      errors++;
      $display("FAIL single_pulses got %0d pulses (%0d wrong length) expected 24", np, bad);
    end
  endtask

  task automatic test_back_to_back();
    s_n = 3;
    for (int i = 0; i < 3; i++) begin s_arr[i] = i; s_pix[i] = 24'($urandom); end
    run_scenario("back_to_back");
  endtask

  task automatic test_overflow();
    int np;
    s_n = 6;
    for (int i = 0; i < 6; i++) begin s_arr[i] = i; s_pix[i] = 24'($urandom) | 24'h800000; end
    run_scenario("overflow");
    np = count_pulses();
    checks++;
    if (np != 5 * 24) begin errors++; $display("FAIL overflow_pulses got %0d expected 120", np); end
    do_reset();
    @(negedge clock);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_cleared got %b expected 0", overflow); end
    @(posedge clock);
    #1;
  endtask

  task automatic test_latch_push();
    s_n = 2;
    s_arr[0] = 0;   s_pix[0] = 24'($urandom);
    s_arr[1] = 2 + PIX + 500; s_pix[1] = 24'($urandom);
    run_scenario("latch_push");
  endtask

  task automatic test_rgb_order();
    int run, idx, bad, want;
`ifdef WS2812_RGB_ORDER_EN
    want = T1H;
`else
    want = T0H;
`endif
    s_n = 1; s_arr[0] = 0; s_pix[0] = 24'hFF0000;
    run_scenario("byte_order");
    run = 0; idx = 0; bad = 0;
    for (int c = 0; c < tr_len && idx < 8; c++) begin
      if (tr_d[c]) run++;
      else if (run != 0) begin
        if (run != want) bad++;
        idx++; run = 0;
      end
    end
    checks++;
    if (bad != 0 || idx != 8) begin
      errors++;
      $display("FAIL first_byte got %0d wrong of %0d pulses, expected 8 pulses of %0d", bad, idx, want);
    end
  endtask

  task automatic test_random(input int iters);
    int a, mode;
    for (int it = 0; it < iters; it++) begin
      s_n = $urandom_range(1, 7);
      a = $urandom_range(0, 5);
      for (int i = 0; i < s_n; i++) begin
        s_arr[i] = a;
        s_pix[i] = 24'($urandom);
        mode = $urandom_range(0, 2);
        a += (mode == 0) ? 1 : (mode == 1) ? $urandom_range(1, 400) : $urandom_range(300, 1000);
      end
      run_scenario($sformatf("random%0d", it));
    end
  endtask

  task automatic test_reset_midframe();
    int pre, post_d, post_b;
    localparam int RC = 2 + 12 * TBIT + 2;
    do_reset();
    pre = 0;
    for (int c = 0; c <= RC; c++) begin
      valid_i = (c < 3);
      {r, g, b} = 24'($urandom);
      reset = (c == RC);
      @(negedge clock);
      tr_d[c] = dout;
      if (c > 0 && tr_d[c] && !tr_d[c-1]) pre++;
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    valid_i = 1'b0;
    @(negedge clock);
    checks += 3;
    if (pre != (RC - 2) / TBIT + 1) begin
      errors++; $display("FAIL midreset_pre_pulses got %0d expected %0d", pre, (RC - 2) / TBIT + 1);
    end
    if (dout !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_next got dout=%b busy=%b expected 0 0", dout, busy);
    end
    post_d = 0; post_b = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clock);
      if (dout) post_d++;
      if (busy) post_b++;
    end
    if (post_d != 0 || post_b != 0) begin
      errors++; $display("FAIL midreset_after got %0d dout-high and %0d busy cycles expected 0", post_d, post_b);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    valid_i = 1'b0;
    {r, g, b} = '0;
    test_reset();
    test_single_pixel();
    test_back_to_back();
    test_overflow();
    test_latch_push();
    test_rgb_order();
    test_reset_midframe();
    test_random(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ws2812_tx.md
WS2812_TX -- requirements
Module: ws2812_tx

Interface
REQ-001 Parameter T0H, default 5, high time of a '0' bit in clock cycles.
REQ-002 Parameter T1H, default 10, high time of a '1' bit in clock cycles.
REQ-003 Parameter TBIT, default 15, total bit period in clock cycles; TBIT > T1H > T0H >= 1.
REQ-004 Parameter TRST, default 960, latch (low) time after the last pixel of a frame, in clock cycles.
REQ-005 Parameter DEPTH, default 4, pixel FIFO depth; power of two.
REQ-006 clock  input  1  Single clock; all logic on its rising edge.
REQ-007 reset  input  1  Synchronous, active-high reset.
REQ-008 r, g, b  input  8 each  Pixel colour from the HSL-to-RGB stage.
REQ-009 valid_i  input  1  Pixel strobe; one pixel per high cycle; no backpressure.
REQ-010 dout  output  1  WS2812 serial data line.
REQ-011 busy  output  1  High when the FIFO is non-empty or state is not IDLE.
REQ-012 overflow  output  1  Sticky flag: a pixel was dropped.

Function
REQ-013 The FIFO SHALL push {r,g,b} on valid_i when not full, or when full with a pop in the same cycle.
REQ-014 valid_i while full with no pop SHALL drop the pixel and set overflow in the next cycle.
REQ-015 States SHALL be IDLE, HIGH, LOW and LATCH.
REQ-016 IDLE: dout=0; when the FIFO is non-empty, pop the head into a 24-bit shift register and go to HIGH.
REQ-017 A pixel pushed at cycle N into an empty FIFO in IDLE SHALL be popped at N+1, with dout=1 from N+2.
REQ-018 HIGH: dout=1 for T0H cycles (bit 0) or T1H cycles (bit 1), MSB first, then go to LOW.
REQ-019 LOW: dout=0 for TBIT minus the high time, so every bit lasts exactly TBIT cycles.
REQ-020 After the 24th bit: if the FIFO is non-empty, pop and enter HIGH with no gap; otherwise enter LATCH.
REQ-021 LATCH: dout=0 for exactly TRST cycles, then IDLE; pixels arriving during LATCH SHALL wait in the FIFO.
REQ-022 Wire order SHALL be G,R,B (each MSB first) unless REQ-027 applies.
REQ-023 Bit and cycle counters SHALL saturate nowhere and wrap only by explicit reload; the bit counter spans 0..23.

Reset
REQ-024 Reset SHALL force state=IDLE, dout=0, busy=0, overflow=0, FIFO empty, and all counters to 0.
REQ-025 Reset asserted mid-bit or mid-frame SHALL abort transmission, with dout=0 in the next cycle and pending pixels discarded.

Configuration
REQ-026 Macro WS2812_RGB_ORDER_EN SHALL select the wire byte order.
REQ-027 With WS2812_RGB_ORDER_EN defined, wire order SHALL be R,G,B (WS2811 strips); without it, order SHALL be G,R,B; timing is identical in both cases.

Structure
REQ-028 Package ws2812_pkg SHALL hold the state enum typedef, the 24-bit pixel typedef and the default timing constants.
REQ-029 The FIFO SHALL be a separate sub-module pixel_fifo, parameterised by width and depth, with push/pop/full/empty ports.

Verification
REQ-030 One pixel r=FF g=00 b=80 (GRB stream 00FF80): eight 5-cycle highs, eight 10-cycle highs, one 10-cycle high, seven 5-cycle highs; 360 cycles of bits, then 960 cycles low; busy falls after LATCH.
REQ-031 Three pixels on consecutive cycles: 1080 continuous bit cycles with no gap and exactly one 960-cycle LATCH.
REQ-032 Six valid_i pulses on consecutive cycles from IDLE (DEPTH=4): the sixth pixel is dropped, overflow=1 from the following cycle, five pixels are transmitted, and overflow stays 1 until reset.
REQ-033 Pixel pushed during LATCH cycle 500: dout stays 0 until LATCH completes, then the pixel is transmitted.
REQ-034 Reset asserted at bit 12 of a pixel with 2 pixels queued: dout=0 next cycle, busy=0, and no further pulses are emitted.
REQ-035 With WS2812_RGB_ORDER_EN defined, r=FF g=00 b=00 emits eight '1' bits first.
